// File: rtl/riscv_regfile.sv
// Integer register file: 2^AW x DW, two registered read ports, one write port, x0 hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN selects write-first reads on a same-cycle address match (default read-first).
module riscv_regfile #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          Clk_i,
   input  logic          Rstn_i,
   input  logic          RdEnA_i,
   input  logic [AW-1:0] RdAddrA_i,
   output logic [DW-1:0] RdDataA_o,
   input  logic          RdEnB_i,
   input  logic [AW-1:0] RdAddrB_i,
   output logic [DW-1:0] RdDataB_o,
   input  logic          WrEn_i,
   input  logic [AW-1:0] WrAddr_i,
   input  logic [DW-1:0] WrData_i
);

   localparam int NREG = 1 << AW;

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] rd_a_q, rd_a_d;
   logic [DW-1:0] rd_b_q, rd_b_d;

   // Entry 0 is reset and never written, so it stays zero; reads of x0 are also forced to zero.
   always_ff @(posedge Clk_i or negedge Rstn_i) begin
      if (!Rstn_i) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (WrEn_i && (WrAddr_i != '0)) begin
         regs_q[WrAddr_i] <= WrData_i;
      end
   end

   always_comb begin
      rd_a_d = rd_a_q;
      if (RdEnA_i) begin
         if (RdAddrA_i == '0) begin
            rd_a_d = '0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (WrEn_i && (WrAddr_i == RdAddrA_i)) begin
            rd_a_d = WrData_i;
         end
`endif
         else begin
            rd_a_d = regs_q[RdAddrA_i];
         end
      end
   end

   always_comb begin
      rd_b_d = rd_b_q;
      if (RdEnB_i) begin
         if (RdAddrB_i == '0) begin
            rd_b_d = '0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (WrEn_i && (WrAddr_i == RdAddrB_i)) begin
            rd_b_d = WrData_i;
         end
`endif
         else begin
            rd_b_d = regs_q[RdAddrB_i];
         end
      end
   end

   always_ff @(posedge Clk_i or negedge Rstn_i) begin
      if (!Rstn_i) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign RdDataA_o = rd_a_q;
   assign RdDataB_o = rd_b_q;

endmodule

// File: tb/tb_riscv_regfile.sv
// Self-checking bench for riscv_regfile: directed scenarios plus randomized traffic against an array model.
// Build with or without REGFILE_BYPASS_EN to match the DUT configuration.
module tb_riscv_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          Clk_i = 1'b0;
   logic          Rstn_i = 1'b0;
   logic          RdEnA_i = 1'b0;
   logic [AW-1:0] RdAddrA_i = '0;
   logic [DW-1:0] RdDataA_o;
   logic          RdEnB_i = 1'b0;
   logic [AW-1:0] RdAddrB_i = '0;
   logic [DW-1:0] RdDataB_o;
   logic          WrEn_i = 1'b0;
   logic [AW-1:0] WrAddr_i = '0;
   logic [DW-1:0] WrData_i = '0;

   riscv_regfile #(.DW(DW), .AW(AW)) dut (
      .Clk_i     (Clk_i),
      .Rstn_i    (Rstn_i),
      .RdEnA_i   (RdEnA_i),
      .RdAddrA_i (RdAddrA_i),
      .RdDataA_o (RdDataA_o),
      .RdEnB_i   (RdEnB_i),
      .RdAddrB_i (RdAddrB_i),
      .RdDataB_o (RdDataB_o),
      .WrEn_i    (WrEn_i),
      .WrAddr_i  (WrAddr_i),
      .WrData_i  (WrData_i)
   );

   always #5 Clk_i = ~Clk_i;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mdl [32];
   logic [DW-1:0] exp_a = '0;
   logic [DW-1:0] exp_b = '0;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [4:0] ra, input logic wen,
                                                input logic [4:0] wa, input logic [DW-1:0] wd);
      if (ra == 5'd0) return '0;
      if (BYPASS && wen && wa == ra) return wd;
      return mdl[ra];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      exp_a = '0;
      exp_b = '0;
   endtask

   // One clock: drive inputs, predict, step past the edge, compare both read ports, commit write.
   task automatic cyc(input string tag, input logic wen, input logic [4:0] wa, input logic [DW-1:0] wd,
                      input logic ena, input logic [4:0] aa, input logic enb, input logic [4:0] ab);
      WrEn_i = wen; WrAddr_i = wa; WrData_i = wd;
      RdEnA_i = ena; RdAddrA_i = aa; RdEnB_i = enb; RdAddrB_i = ab;
      if (ena) exp_a = model_read(aa, wen, wa, wd);
      if (enb) exp_b = model_read(ab, wen, wa, wd);
      @(posedge Clk_i);
      #1;
      if (wen && wa != 5'd0) mdl[wa] = wd;
      check_val({tag, ".A"}, RdDataA_o, exp_a);
      check_val({tag, ".B"}, RdDataB_o, exp_b);
   endtask

   task automatic idle();
      cyc("idle", 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   // Reset pulse entirely between clock edges, with a write being presented when it hits.
   task automatic reset_pulse(input string tag);
      #3;
      Rstn_i = 1'b0;
      #1;
      WrEn_i = 1'b0;
      model_clear();
      check_val({tag, ".rstA"}, RdDataA_o, '0);
      check_val({tag, ".rstB"}, RdDataB_o, '0);
      #1;
      Rstn_i = 1'b1;
   endtask

   initial begin
      model_clear();
      repeat (2) @(posedge Clk_i);
      #1;
      check_val("por.A", RdDataA_o, '0);
      check_val("por.B", RdDataB_o, '0);
      Rstn_i = 1'b1;

      // Scenario 1: reset held 3 cycles clears outputs immediately and storage
      cyc("t1.wr", 1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("t1.rd", 1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b1, 5'd5);
      #2;
      Rstn_i = 1'b0;
      #1;
      model_clear();
      check_val("t1.rstA", RdDataA_o, '0);
      check_val("t1.rstB", RdDataB_o, '0);
      repeat (3) @(posedge Clk_i);
      #2;
      Rstn_i = 1'b1;
      cyc("t1.after", 1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b1, 5'd5);

      // Scenario 2: write then read one cycle later
      cyc("t2.wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("t2.rd", 1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b0, 5'd0);
      check_val("t2.val", RdDataA_o, 32'hDEAD_BEEF);

      // Scenario 3: x0 ignores writes
      cyc("t3.wr", 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("t3.rd", 1'b0, 5'd0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
      check_val("t3.x0A", RdDataA_o, '0);
      check_val("t3.x0B", RdDataB_o, '0);
      cyc("t3.samecyc", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);

      // Scenario 4: same-edge write/read collision
      cyc("t4.init", 1'b1, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("t4.coll", 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b0, 5'd0);
      check_val("t4.coll_val", RdDataA_o, BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001);
      cyc("t4.next", 1'b0, 5'd0, '0, 1'b1, 5'd7, 1'b0, 5'd0);
      check_val("t4.next_val", RdDataA_o, 32'hA5A5_A5A5);

      // Scenario 5: port B holds while disabled and the address sweeps
      cyc("t5.wr", 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b0, 5'd0);
      cyc("t5.rd", 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 5'd3);
      for (int a = 1; a < 32; a++) begin
         cyc("t5.hold", 1'b1, 5'(a), 32'hCAFE_0000 | 32'(a), 1'b0, 5'd0, 1'b0, 5'(a));
      end
      check_val("t5.held", RdDataB_o, 32'h0000_0033);

      // Scenario 6: reset pulse during back-to-back writes
      for (int a = 1; a < 32; a++) begin
         cyc("t6.fill", 1'b1, 5'(a), 32'h1000_0000 + 32'(a), 1'b1, 5'(a), 1'b1, 5'(32 - a));
      end
      WrEn_i = 1'b1; WrAddr_i = 5'd9; WrData_i = 32'h9999_9999;
      reset_pulse("t6");
      for (int a = 0; a < 32; a++) begin
         cyc("t6.scan", 1'b0, 5'd0, '0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
         check_val("t6.zeroA", RdDataA_o, '0);
      end

      // Randomized traffic, biased toward a few addresses to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] wa, aa, ab;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         aa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         ab = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         cyc("rnd", 1'($urandom), wa, $urandom, 1'($urandom), aa, 1'($urandom), ab);
         if ($urandom_range(0, 199) == 0) begin
            WrEn_i = 1'b1; WrAddr_i = 5'($urandom_range(1, 31)); WrData_i = $urandom;
            reset_pulse("rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
